// File: rtl/ula_seq_ctrl.sv
// Sequencing controller in front of the ULA datapath: accepts one request, holds operands
// for the op's settle time, returns the mux result. Optional flags: ULA_SEQ_CTRL_FLAGS_EN.
module ula_seq_ctrl #(
  parameter int DATA_W = 8,
  parameter int MC_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_opcode,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic [4:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_err,
`ifdef ULA_SEQ_CTRL_FLAGS_EN
  output logic              out_zero,
  output logic              out_neg,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [4:0] OP_MUL      = 5'b00010;
  localparam logic [4:0] OP_DIV      = 5'b00011;
  localparam logic [3:0] CNT_INIT    = 4'(MC_LAT - 1);

  // Legal op count per category: 00 -> 0..5, 01 -> 0..6, 10 -> 0..4, 11 -> none.
  function automatic logic f_is_legal(input logic [4:0] op);
    logic v;
    case (op[4:3])
      2'b00:   v = (op[2:0] <= 3'd5);
      2'b01:   v = (op[2:0] <= 3'd6);
      2'b10:   v = (op[2:0] <= 3'd4);
      default: v = 1'b0;
    endcase
    return v;
  endfunction

  state_t              r_state, w_state_nxt;
  logic [3:0]          r_cnt, w_cnt_nxt;
  logic [4:0]          r_opc, w_opc_nxt;
  logic [DATA_W-1:0]   r_a, w_a_nxt;
  logic [DATA_W-1:0]   r_b, w_b_nxt;
  logic [DATA_W-1:0]   r_res, w_res_nxt;
  logic                r_err, w_err_nxt;
  logic                w_cap;

  // State register plus operand/result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_opc   <= 5'd0;
      r_a     <= {DATA_W{1'b0}};
      r_b     <= {DATA_W{1'b0}};
      r_res   <= {DATA_W{1'b0}};
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_opc   <= w_opc_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_res   <= w_res_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state and next-register decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_opc_nxt   = r_opc;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_res_nxt   = r_res;
    w_err_nxt   = r_err;
    w_cap       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_opc_nxt = in_opcode;
          w_a_nxt   = in_a;
          w_b_nxt   = in_b;
          if (!f_is_legal(in_opcode)) begin
            w_res_nxt   = {DATA_W{1'b0}};
            w_err_nxt   = 1'b1;
            w_cap       = 1'b1;
            w_state_nxt = S_DONE;
          end else if ((in_opcode == OP_MUL) || (in_opcode == OP_DIV)) begin
            w_cnt_nxt   = CNT_INIT;
            w_state_nxt = S_WAIT;
          end else begin
            w_state_nxt = S_EXEC;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_EXEC: begin
        w_res_nxt   = alu_result;
        w_err_nxt   = 1'b0;
        w_cap       = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_WAIT: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          // Divide-by-zero result is defined here, not by whatever the divider produces.
          if ((r_opc == OP_DIV) && (r_b == {DATA_W{1'b0}})) begin
            w_res_nxt = {DATA_W{1'b1}};
            w_err_nxt = 1'b1;
          end else begin
            w_res_nxt = alu_result;
            w_err_nxt = 1'b0;
          end
          w_cap       = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

`ifdef ULA_SEQ_CTRL_FLAGS_EN
  logic r_zero, r_neg;

  // Result flags, updated only when a new result is captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
    end else if (w_cap) begin
      r_zero <= !w_err_nxt && (w_res_nxt == {DATA_W{1'b0}});
      r_neg  <= !w_err_nxt && w_res_nxt[DATA_W-1];
    end else begin
      r_zero <= r_zero;
      r_neg  <= r_neg;
    end
  end

  assign out_zero = r_zero;
  assign out_neg  = r_neg;
`else
  logic w_cap_unused;
  assign w_cap_unused = w_cap;
`endif

  assign in_ready   = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign out_valid  = (r_state == S_DONE);
  assign alu_opcode = r_opc;
  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign out_result = r_res;
  assign out_err    = r_err;

endmodule

// File: doc/ula_seq_ctrl.md
Name: ula_seq_ctrl

Overview:
- Sequencing controller in front of the ULA datapath (arithmetic/logic/shifter units plus the central result mux).
- Accepts one operation request at a time over a valid/ready handshake.
- Registers the operands and the 5-bit opcode and drives them to the datapath. Holds them stable for a fixed number of cycles per operation class: multi-cycle for MUL/DIV, single-cycle otherwise.
- Captures the mux result and returns it over a second valid/ready handshake with an error flag.

Parameters:
- DATA_W, 8: operand/result width.
- MC_LAT, 4: settle cycles granted to MUL (00010) and DIV (00011); legal range 1..15.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  controller can accept a request.
- in_opcode  input  5  [4:3] category, [2:0] operation.
- in_a  input  DATA_W  operand A.
- in_b  input  DATA_W  operand B.
- alu_opcode  output  5  registered opcode to the datapath/mux.
- alu_a  output  DATA_W  registered operand A to the datapath.
- alu_b  output  DATA_W  registered operand B to the datapath.
- alu_result  input  DATA_W  result from the ULA output mux.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_result  output  DATA_W  captured result.
- out_err  output  1  illegal opcode or divide-by-zero.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values (asynchronous, immediate): state=IDLE, alu_opcode=0, alu_a=0, alu_b=0, out_result=0, out_err=0, out_valid=0, busy=0, counter=0. An in-flight operation is discarded with no output.
- Legal opcodes:
  - Category 00: ops 0..5.
  - Category 01: ops 0..6.
  - Category 10: ops 0..4.
  - Everything else, including all of category 11, is illegal.
- FSM states: IDLE, EXEC, WAIT, DONE.
- IDLE:
  - in_ready=1.
  - On a clock edge with in_valid=1, capture in_opcode/in_a/in_b into alu_opcode/alu_a/alu_b.
  - Illegal opcode: out_result=0, out_err=1, go to DONE.
  - MUL or DIV: counter=MC_LAT-1, go to WAIT.
  - Otherwise: go to EXEC.
- EXEC:
  - Exactly one cycle.
  - At the next edge: out_result<=alu_result, out_err<=0, go to DONE.
- WAIT:
  - At each edge where counter≠0: counter decrements.
  - At the edge where counter==0: out_result<=alu_result, go to DONE.
  - out_err<=1 only for DIV with alu_b==0; in that case out_result is forced to all-ones.
- DONE:
  - out_valid=1, in_ready=0.
  - out_result and out_err are held stable.
  - On an edge with out_ready=1, go to IDLE.
  - out_valid drops in the cycle after that edge.
  - No new request is accepted in the same cycle as the DONE→IDLE transition.
- Latency, for a request accepted at edge k, out_valid is first high after:
  - Illegal opcode: edge k.
  - Single-cycle op: edge k+1.
  - MUL/DIV: edge k+MC_LAT.
- Stability: alu_opcode, alu_a and alu_b hold from acceptance until the next acceptance; they are not cleared on returning to IDLE.
- in_ready is combinational from state only (no dependency on in_valid).
- out_ready may be held high permanently; a result is then consumed in its first valid cycle.
- Throughput:
  - One operation per 3 cycles minimum for single-cycle ops.
  - One operation per MC_LAT+2 cycles for MUL/DIV.

Optional Feature:
- Macro: ULA_SEQ_CTRL_FLAGS_EN.
- When defined: two extra outputs, out_zero (out_result==0) and out_neg (out_result[DATA_W-1]).
  - Both are registered in the same edge as out_result.
  - Both reset to 0.
  - Both are forced to 0 when out_err=1.
- When undefined: the ports and their registers are absent. All other behaviour is identical.

Test Plan:
- Reset, then ADD (00000) A=8'h05, B=8'h03, out_ready=1 → out_valid high 1 edge after accept, alu_opcode=00000, out_result equals mux value 8'h08, out_err=0, back to IDLE next edge.
- MUL (00010) A=8'h04, B=8'h03, MC_LAT=4 → in_ready=0 and alu_a/alu_b stable for 4 cycles, out_valid after edge k+4, out_result=8'h0C.
- DIV (00011) A=8'h10, B=8'h00 → out_err=1, out_result=8'hFF after MC_LAT edges.
- Illegal opcode 11000, then 01111 → each gives out_valid one cycle after accept, out_result=0, out_err=1.
- XOR request, then out_ready held 0 for 5 cycles → out_valid and out_result held; a second in_valid is ignored (in_ready=0) until one edge after out_ready=1.
- rst pulsed mid-WAIT of a MUL → all outputs 0 immediately, state IDLE, no out_valid for the aborted op; the next ADD completes normally.
